// File: rtl/csr_bank.sv
// CSR bank driven by a slow host through asynchronous level strobes: masked config registers, read-only status.
// Optional CSR_STATUS_STICKY_EN: status bits accumulate and clear on a completed status read.
module csr_bank #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 12,
    parameter int NUM_STATUS_REG = 4,
    parameter int SYNC_STAGES    = 2,
    parameter logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] CONFIG_RST_VAL = '0,
    parameter logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] CONFIG_WMASK   = '1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  logic [DATA_WIDTH-1:0]                write_data_i,
    input  logic                                 write_en_i,
    input  logic                                 read_en_i,
    output logic [DATA_WIDTH-1:0]                read_data_o,
    output logic                                 read_valid_o,
    output logic                                 err_o,
    output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
    output logic [NUM_CONFIG_REG-1:0]            config_update_o,
    input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i,
    output logic [1:0]                           dbg_state_o
);

    localparam int DW = DATA_WIDTH;
    localparam int NC = NUM_CONFIG_REG;
    localparam int NS = NUM_STATUS_REG;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RD_HOLD} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
    logic                    wr_edge_q, wr_edge_d, rd_edge_q, rd_edge_d;
    logic [NC*DW-1:0]        cfg_q, cfg_d;
    logic [NS*DW-1:0]        stat_samp_q, stat_samp_d;
    logic [NS*DW-1:0]        stat_view;
    logic [DW-1:0]           read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    err_q, err_d;
    logic [NC-1:0]           upd_pend_q, upd_pend_d;
    logic [NC-1:0]           upd_q, upd_d;
    logic                    wr_stb, rd_stb, rd_lvl;
    logic                    addr_is_cfg, addr_is_stat;
    logic [DW-1:0]           cfg_sel, stat_sel;

`ifdef CSR_STATUS_STICKY_EN
    logic [NS*DW-1:0]        stat_sticky_q, stat_sticky_d;
    assign stat_view = stat_sticky_q;
`else
    assign stat_view = stat_samp_q;
`endif

    assign wr_stb = wr_sync_q[SYNC_STAGES-1] & ~wr_edge_q;
    assign rd_stb = rd_sync_q[SYNC_STAGES-1] & ~rd_edge_q;
    assign rd_lvl = rd_sync_q[SYNC_STAGES-1];

    assign addr_is_cfg  = 32'(addr_i) < 32'(NC);
    assign addr_is_stat = !addr_is_cfg && (32'(addr_i) < 32'(NC + NS));

    always_comb begin
        cfg_sel  = '0;
        stat_sel = '0;
        for (int i = 0; i < NC; i++) begin
            if (addr_i == ADDR_WIDTH'(i)) cfg_sel = cfg_q[i*DW +: DW];
        end
        for (int j = 0; j < NS; j++) begin
            if (addr_i == ADDR_WIDTH'(NC + j)) stat_sel = stat_view[j*DW +: DW];
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_sync_d    = {wr_sync_q[SYNC_STAGES-2:0], write_en_i};
        rd_sync_d    = {rd_sync_q[SYNC_STAGES-2:0], read_en_i};
        wr_edge_d    = wr_sync_q[SYNC_STAGES-1];
        rd_edge_d    = rd_sync_q[SYNC_STAGES-1];
        cfg_d        = cfg_q;
        stat_samp_d  = status_bus_i;
        read_data_d  = read_data_q;
        read_valid_d = read_valid_q;
        err_d        = 1'b0;
        upd_pend_d   = '0;
        upd_d        = upd_pend_q;
`ifdef CSR_STATUS_STICKY_EN
        stat_sticky_d = stat_sticky_q | stat_samp_q;
`endif

        // Any strobe that finds the FSM busy is dropped and flagged.
        if (state_q != ST_IDLE && (wr_stb || rd_stb)) err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (wr_stb) begin
                    state_d = ST_WRITE;
                    if (rd_stb) err_d = 1'b1;
                end else if (rd_stb) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (addr_is_cfg) begin
                    for (int i = 0; i < NC; i++) begin
                        if (addr_i == ADDR_WIDTH'(i)) begin
                            cfg_d[i*DW +: DW] = (cfg_q[i*DW +: DW] & ~CONFIG_WMASK[i*DW +: DW])
                                              | (write_data_i & CONFIG_WMASK[i*DW +: DW]);
                            upd_pend_d[i] = 1'b1;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_READ: begin
                state_d      = ST_RD_HOLD;
                read_valid_d = 1'b1;
                if (addr_is_cfg) begin
                    read_data_d = cfg_sel;
                end else if (addr_is_stat) begin
                    read_data_d = stat_sel;
`ifdef CSR_STATUS_STICKY_EN
                    // Clear-on-read keeps only bits that are being set this very cycle.
                    for (int j = 0; j < NS; j++) begin
                        if (addr_i == ADDR_WIDTH'(NC + j)) stat_sticky_d[j*DW +: DW] = stat_samp_q[j*DW +: DW];
                    end
`endif
                end else begin
                    read_data_d = '1;
                    err_d       = 1'b1;
                end
            end
            ST_RD_HOLD: begin
                // Level test rather than edge so a read strobe shorter than READ cannot strand the FSM.
                if (!rd_lvl) begin
                    state_d      = ST_IDLE;
                    read_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            wr_sync_q    <= '0;
            rd_sync_q    <= '0;
            wr_edge_q    <= 1'b0;
            rd_edge_q    <= 1'b0;
            cfg_q        <= CONFIG_RST_VAL;
            stat_samp_q  <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            err_q        <= 1'b0;
            upd_pend_q   <= '0;
            upd_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_sync_q    <= wr_sync_d;
            rd_sync_q    <= rd_sync_d;
            wr_edge_q    <= wr_edge_d;
            rd_edge_q    <= rd_edge_d;
            cfg_q        <= cfg_d;
            stat_samp_q  <= stat_samp_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            err_q        <= err_d;
            upd_pend_q   <= upd_pend_d;
            upd_q        <= upd_d;
        end
    end

`ifdef CSR_STATUS_STICKY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stat_sticky_q <= '0;
        else         stat_sticky_q <= stat_sticky_d;
    end
`endif

    assign read_data_o     = read_data_q;
    assign read_valid_o    = read_valid_q;
    assign err_o           = err_q;
    assign config_bus_o    = cfg_q;
    assign config_update_o = upd_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: reset checks, a directed vector table, hand-written corner sequences,
// and a randomized phase checked against a register-array model.
module tb_csr_bank;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NC = 12;
  localparam int NS = 4;
  localparam int S  = 2;
  localparam logic [NC*DW-1:0] RST_VAL = 96'h00000000_00000000_A5000000;
  localparam logic [NC*DW-1:0] WMASK   = 96'hFFFFFFFF_FFFFFFFF_FF0FFFFF;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              wen;
  logic              ren;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic              err;
  logic [NC*DW-1:0]  cfg_bus;
  logic [NC-1:0]     cfg_upd;
  logic [NS*DW-1:0]  status;
  logic [1:0]        dbg_state;

  csr_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONFIG_REG(NC), .NUM_STATUS_REG(NS),
    .SYNC_STAGES(S), .CONFIG_RST_VAL(RST_VAL), .CONFIG_WMASK(WMASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .write_data_i(wdata),
    .write_en_i(wen), .read_en_i(ren), .read_data_o(rdata), .read_valid_o(rvalid),
    .err_o(err), .config_bus_o(cfg_bus), .config_update_o(cfg_upd),
    .status_bus_i(status), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model
  logic [DW-1:0] rst_m[NC];
  logic [DW-1:0] mask_m[NC];
  logic [DW-1:0] cfg_m[NC];
  logic [DW-1:0] live_m[NS];
  logic [DW-1:0] sticky_m[NS];

  function automatic logic [NC*DW-1:0] pack_cfg();
    logic [NC*DW-1:0] b;
    b = '0;
    for (int i = 0; i < NC; i++) b[i*DW +: DW] = cfg_m[i];
    return b;
  endfunction

  // driver tasks (inputs change on negedge, outputs sampled on negedge)
  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int exp_err, input logic [NC-1:0] exp_upd);
    int errs = 0;
    int hits = 0;
    int upd_at = -1;
    logic [NC-1:0] upd_val = '0;
    addr = a;
    wdata = d;
    wen = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (err) errs++;
      if (cfg_upd != '0) begin
        hits++;
        upd_at = k;
        upd_val = cfg_upd;
      end
      if (k == 8) wen = 1'b0;
    end
    chk("wr_err_count", 96'(errs), 96'(exp_err));
    chk("wr_upd_count", 96'(hits), (exp_upd != '0) ? 96'd1 : 96'd0);
    if (exp_upd != '0) begin
      chk("wr_upd_mask", 96'(upd_val), 96'(exp_upd));
      chk("wr_upd_edge", 96'(upd_at), 96'(S + 3));
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input int exp_err);
    int errs = 0;
    logic v_pre = 1'b0, v_post = 1'b0, f_pre = 1'b0, f_post = 1'b0;
    logic [DW-1:0] d_at = '0;
    addr = a;
    ren = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (err) errs++;
      if (k == S + 1) v_pre = rvalid;
      if (k == S + 2) begin
        v_post = rvalid;
        d_at = rdata;
      end
      if (k == 10) ren = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (err) errs++;
      if (k == S) f_pre = rvalid;
      if (k == S + 1) f_post = rvalid;
    end
    chk("rd_data", 96'(d_at), 96'(exp_d));
    chk("rd_valid_rise", 96'({v_pre, v_post}), 96'(2'b01));
    chk("rd_valid_fall", 96'({f_pre, f_post}), 96'(2'b10));
    chk("rd_data_hold", 96'(rdata), 96'(exp_d));
    chk("rd_err_count", 96'(errs), 96'(exp_err));
  endtask

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NS*DW-1:0] st;
    logic [DW-1:0] exp_val;
    int            exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [NC*DW-1:0] bus_before;
    logic [DW-1:0] exp_d;
    int exp_e;
    int hits, errs, vcnt;

    rst_n = 1'b0; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0; status = '0;
    for (int i = 0; i < NC; i++) begin
      rst_m[i]  = 8'h00;
      mask_m[i] = 8'hFF;
    end
    rst_m[3]  = 8'hA5;
    mask_m[2] = 8'h0F;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cfg_bus", 96'(cfg_bus), 96'h00000000_00000000_A5000000);
    chk("rst_valid", 96'(rvalid), 96'd0);
    chk("rst_err", 96'(err), 96'd0);
    chk("rst_upd", 96'(cfg_upd), 96'd0);
    chk("rst_rdata", 96'(rdata), 96'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_cfg_bus", 96'(cfg_bus), 96'h00000000_00000000_A5000000);

    // directed vectors: {rd, addr, wdata, status, expected value, expected errors}
    vecs[0]  = '{0, 7'd2,   8'h3C, 32'h00000000, 8'h0C, 0};
    vecs[1]  = '{1, 7'd2,   8'h00, 32'h00000000, 8'h0C, 0};
    vecs[2]  = '{1, 7'd3,   8'h00, 32'h00000000, 8'hA5, 0};
    vecs[3]  = '{1, 7'd13,  8'h00, 32'h00005A00, 8'h5A, 0};
    vecs[4]  = '{0, 7'd12,  8'h55, 32'h00005A00, 8'h00, 1};
    vecs[5]  = '{1, 7'd100, 8'h00, 32'h00005A00, 8'hFF, 1};
    vecs[6]  = '{0, 7'd11,  8'hFF, 32'h00005A00, 8'hFF, 0};
    vecs[7]  = '{1, 7'd11,  8'h00, 32'h00005A00, 8'hFF, 0};
    vecs[8]  = '{0, 7'd2,   8'h0C, 32'h00005A00, 8'h0C, 0};
    vecs[9]  = '{1, 7'd15,  8'h00, 32'hC3000000, 8'hC3, 0};
    vecs[10] = '{1, 7'd16,  8'h00, 32'hC3000000, 8'hFF, 1};
    vecs[11] = '{0, 7'd127, 8'h99, 32'hC3000000, 8'h00, 1};
    vecs[12] = '{1, 7'd0,   8'h00, 32'hC3000000, 8'h00, 0};

    for (int n = 0; n < 13; n++) begin
      status = vecs[n].st;
      if (vecs[n].rd) begin
        run_read(vecs[n].a, vecs[n].exp_val, vecs[n].exp_err);
      end else begin
        bus_before = cfg_bus;
        run_write(vecs[n].a, vecs[n].d, vecs[n].exp_err,
                  (vecs[n].exp_err != 0) ? 12'h000 : (12'h001 << vecs[n].a));
        if (vecs[n].exp_err != 0) chk("wr_bus_unchanged", 96'(cfg_bus), 96'(bus_before));
        else chk("wr_reg_value", 96'(cfg_bus[vecs[n].a*DW +: DW]), 96'(vecs[n].exp_val));
      end
    end

    // both strobes on the same edge: write wins, read dropped with one error
    addr = 7'd1; wdata = 8'h77; wen = 1'b1; ren = 1'b1;
    hits = 0; errs = 0; vcnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (err) errs++;
      if (rvalid) vcnt++;
      if (cfg_upd != '0) hits++;
      if (k == 8) begin
        wen = 1'b0;
        ren = 1'b0;
      end
    end
    chk("both_reg1", 96'(cfg_bus[15:8]), 96'h77);
    chk("both_err", 96'(errs), 96'd1);
    chk("both_no_valid", 96'(vcnt), 96'd0);
    chk("both_upd", 96'(hits), 96'd1);

    // one-cycle pulse on status bit 0 of reg 12, then two reads
    status = '0;
    repeat (3) @(negedge clk);
    status[0] = 1'b1;
    @(negedge clk);
    status[0] = 1'b0;
    repeat (3) @(negedge clk);
`ifdef CSR_STATUS_STICKY_EN
    run_read(7'd12, 8'h01, 0);
`else
    run_read(7'd12, 8'h00, 0);
`endif
    run_read(7'd12, 8'h00, 0);

    // reset in the middle of a write aborts it
    addr = 7'd0; wdata = 8'hAA; wen = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    wen = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_cfg_bus", 96'(cfg_bus), 96'h00000000_00000000_A5000000);
    chk("midrst_valid", 96'(rvalid), 96'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_after_bus", 96'(cfg_bus), 96'h00000000_00000000_A5000000);
    chk("midrst_after_upd", 96'(cfg_upd), 96'd0);

    // randomized phase against the model
    for (int i = 0; i < NC; i++) cfg_m[i] = rst_m[i];
    for (int j = 0; j < NS; j++) begin
      live_m[j] = 8'h00;
      sticky_m[j] = 8'h00;
    end
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(16, 127));
      else a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        status = $urandom;
        for (int j = 0; j < NS; j++) begin
          live_m[j] = status[j*DW +: DW];
          sticky_m[j] = sticky_m[j] | live_m[j];
        end
        exp_e = 0;
        if (int'(a) < NC) begin
          exp_d = cfg_m[a];
        end else if (int'(a) < NC + NS) begin
`ifdef CSR_STATUS_STICKY_EN
          exp_d = sticky_m[int'(a) - NC];
          sticky_m[int'(a) - NC] = live_m[int'(a) - NC];
`else
          exp_d = live_m[int'(a) - NC];
`endif
        end else begin
          exp_d = 8'hFF;
          exp_e = 1;
        end
        run_read(a, exp_d, exp_e);
      end else begin
        logic [DW-1:0] d;
        d = DW'($urandom);
        if (int'(a) < NC) begin
          cfg_m[a] = (cfg_m[a] & ~mask_m[a]) | (d & mask_m[a]);
          run_write(a, d, 0, NC'(1) << a);
        end else begin
          run_write(a, d, 1, '0);
        end
        chk("rand_cfg_bus", 96'(cfg_bus), 96'(pack_cfg()));
      end
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
